mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequences every MEM-stage data access onto a 16-bit asynchronous external SRAM.
- Each 32-bit load or store is split into two 16-bit halves, low half first, then high half.
- While an access is in progress, the block asserts freeze, which the team's pipeline registers use to hold their contents (IF/ID/EX/MEM/WB).
- It returns the assembled 32-bit load word as Mem_read_value to the MEM/WB register.

Parameters:
- SRAM_AW, 17, SRAM halfword address width.
- WAIT_CYCLES, 2, extra cycles per half-phase beyond the first. Legal range 1..7.
- BASE_ADDR, 1024, byte address mapped to SRAM halfword 0.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- MEM_R_en  in  1  load request from the EX/MEM register.
- MEM_W_en  in  1  store request from the EX/MEM register.
- ALU_result  in  32  byte address.
- ST_val  in  32  store data.
- freeze  out  1  pipeline hold.
- Mem_read_value  out  32  last completed load word.
- ready  out  1  one-cycle pulse when an access completes.
- SRAM_ADDR  out  SRAM_AW  halfword address.
- SRAM_DQ_out  out  16  write data.
- SRAM_DQ_in  in  16  read data.
- SRAM_DQ_oe  out  1  data bus drive enable; the top level builds the tristate.
- SRAM_WE_N  out  1  active-low write strobe.
- SRAM_OE_N  out  1  active-low output enable.

Behaviour:
- Reset:
  - rst low asynchronously forces state IDLE and counter 0.
  - Output values under reset: Mem_read_value 0, ready 0, SRAM_ADDR 0, SRAM_DQ_out 0, SRAM_DQ_oe 0, SRAM_WE_N 1, SRAM_OE_N 1.
  - freeze is forced 0 while rst is low.
- Reset mid-access: the access is aborted immediately and WE_N/OE_N are released in the same instant. No partial read data is written into Mem_read_value.
- Address mapping:
  - word = (ALU_result - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits. Wrap-around is silent.
  - Low half is at {word,0}; high half is at {word,1}.
  - Address bits [1:0] are ignored.
- Request decode in IDLE:
  - req = MEM_R_en | MEM_W_en.
  - If both are set, the access is a store; no read data is captured.
- freeze:
  - freeze = req when state is IDLE.
  - freeze = 1 in LO and HI.
  - freeze = 0 in DONE.
  - freeze is combinational so the pipeline holds in the same cycle the request is seen.
- FSM, with states IDLE, LO, HI, DONE:
  - IDLE & req: latch the operation, address and ST_val; go to LO; counter = 0.
  - LO: lasts WAIT_CYCLES+1 cycles; counter counts 0..WAIT_CYCLES, then go to HI with counter = 0.
  - HI: same length as LO, then go to DONE.
  - DONE: one cycle; ready = 1; go to IDLE.
  - IDLE & !req: stay in IDLE.
- Outputs per phase (all registered):
  - SRAM_ADDR holds the phase address for the whole phase.
  - Store:
    - SRAM_DQ_oe = 1 and SRAM_DQ_out = ST_val[15:0] in LO, ST_val[31:16] in HI.
    - SRAM_WE_N = 0 on every phase cycle except the last, so the write strobe rises before the address changes.
    - SRAM_OE_N = 1.
  - Load:
    - SRAM_OE_N = 0 for the whole phase and SRAM_DQ_oe = 0.
    - SRAM_DQ_in is sampled on the last cycle of each phase into the low or high holding register.
    - Mem_read_value updates when entering DONE.
  - IDLE and DONE: strobes are inactive and SRAM_DQ_oe = 0.
- Mem_read_value holds its value across stores and idle cycles until the next load completes.
- Latency: total latency is 2*(WAIT_CYCLES+1)+1 cycles. With the default of 2, the request is seen at cycle 0, freeze is high for cycles 0..6, ready is high at cycle 7, and the pipeline advances at the end of cycle 7.
- Back-to-back accesses: the request for the next instruction is seen in IDLE on the cycle after DONE. There are no lost or duplicated accesses.
- Request inputs are ignored outside IDLE; the latched values are used instead.

Test Plan:
- Reset behaviour: hold rst low for 3 cycles with MEM_R_en = 1 -> freeze = 0, WE_N = OE_N = 1, Mem_read_value = 0.
- Store: store ALU_result = 1032, ST_val = 0xDEADBEEF ->
  - SRAM_ADDR = 4, DQ_out = 0xBEEF, WE_N low for 2 of 3 cycles.
  - Then SRAM_ADDR = 5, DQ_out = 0xDEAD.
  - freeze high for 7 cycles; ready pulses at cycle 7.
- Load: load from 1032 with the SRAM model returning 0xBEEF at address 4 and 0xDEAD at address 5 -> Mem_read_value = 0xDEADBEEF at DONE, unchanged afterwards.
- Back-to-back: load 1024 followed immediately by store 1028 -> two separate 7-cycle freeze windows with exactly one idle-decode cycle between them; the SRAM model sees both accesses exactly once.
- Reset mid-access: pulse rst low during the HI phase of a store -> WE_N = 1 and DQ_oe = 0 asynchronously; the block is in IDLE after release; Mem_read_value is unchanged at 0.
- Both requests and wrap-around: MEM_R_en = MEM_W_en = 1 -> treated as a store. Address 1020 (below BASE_ADDR) -> word wraps to 0xFFFF, SRAM_ADDR = 0x1FFFE then 0x1FFFF.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences 32-bit MEM-stage loads/stores onto a 16-bit
// asynchronous SRAM as two half-word phases (low half, then high half).
// The pipeline is frozen while an access is in flight. All SRAM-side
// outputs are registered. The FSM state is exported on dbg_state_o.
module mem_access_ctrl #(
  parameter int unsigned SRAM_AW     = 17,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_en,
  input  logic               MEM_W_en,
  input  logic [31:0]        ALU_result,
  input  logic [31:0]        ST_val,
  output logic               freeze,
  output logic [31:0]        Mem_read_value,
  output logic               ready,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [15:0]        SRAM_DQ_out,
  input  logic [15:0]        SRAM_DQ_in,
  output logic               SRAM_DQ_oe,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic [1:0]         dbg_state_o
);

  // Handshake: a request (MEM_R_en | MEM_W_en) is accepted only in IDLE.
  // freeze is raised combinationally in that same cycle and stays high until
  // the DONE cycle, where ready pulses for exactly one cycle and the pipeline
  // advances. Request inputs are ignored outside IDLE.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 is_store_q, is_store_d;
  logic [SRAM_AW-2:0]   word_q, word_d;
  logic [31:0]          st_q, st_d;
  logic [15:0]          lo_q, lo_d;
  logic [31:0]          rdata_q, rdata_d;

  logic [SRAM_AW-1:0]   addr_q, addr_d;
  logic [15:0]          dq_out_q, dq_out_d;
  logic                 dq_oe_q, dq_oe_d;
  logic                 we_n_q, we_n_d;
  logic                 oe_n_q, oe_n_d;
  logic                 ready_q, ready_d;

  logic                 req;
  logic                 phase_last;
  logic [31:0]          offset;
  logic                 unused_bits;

  assign req        = MEM_R_en | MEM_W_en;
  assign phase_last = (cnt_q == LAST_CNT);
  // Byte offset from the SRAM window; bits [1:0] and anything above the
  // halfword-address range are dropped, so out-of-window addresses wrap.
  assign offset      = ALU_result - BASE_ADDR;
  assign unused_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  // Next-state logic: phase sequencing, request latching, read capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_store_d = is_store_q;
    word_d     = word_q;
    st_d       = st_q;
    lo_d       = lo_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d    = LO;
          cnt_d      = 3'd0;
          is_store_d = MEM_W_en;
          word_d     = offset[SRAM_AW:2];
          st_d       = ST_val;
        end
      end
      LO: begin
        if (phase_last) begin
          state_d = HI;
          cnt_d   = 3'd0;
          if (!is_store_q) lo_d = SRAM_DQ_in;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      HI: begin
        if (phase_last) begin
          state_d = DONE;
          cnt_d   = 3'd0;
          if (!is_store_q) rdata_d = {SRAM_DQ_in, lo_q};
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered SRAM outputs, derived from where the FSM will be next cycle.
  // WE_N goes high on the last cycle of a store phase so the write strobe
  // rises before the address moves on.
  always_comb begin
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    dq_oe_d  = 1'b0;
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    ready_d  = (state_d == DONE);
    if ((state_d == LO) || (state_d == HI)) begin
      addr_d = {word_d, (state_d == HI)};
      if (is_store_d) begin
        dq_oe_d  = 1'b1;
        dq_out_d = (state_d == HI) ? st_d[31:16] : st_d[15:0];
        we_n_d   = (cnt_d == LAST_CNT);
      end else begin
        oe_n_d = 1'b0;
      end
    end
  end

  // State and output registers; reset aborts any access and releases strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      is_store_q <= 1'b0;
      word_q     <= '0;
      st_q       <= '0;
      lo_q       <= '0;
      rdata_q    <= '0;
      addr_q     <= '0;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_store_q <= is_store_d;
      word_q     <= word_d;
      st_q       <= st_d;
      lo_q       <= lo_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      we_n_q     <= we_n_d;
      oe_n_q     <= oe_n_d;
      ready_q    <= ready_d;
    end
  end

  // freeze is combinational so the pipeline holds in the request cycle.
  always_comb begin
    freeze = 1'b0;
    if (rst) begin
      if (state_q == IDLE) freeze = req;
      else                 freeze = (state_q != DONE);
    end
  end

  assign Mem_read_value = rdata_q;
  assign ready          = ready_q;
  assign SRAM_ADDR      = addr_q;
  assign SRAM_DQ_out    = dq_out_q;
  assign SRAM_DQ_oe     = dq_oe_q;
  assign SRAM_WE_N      = we_n_q;
  assign SRAM_OE_N      = oe_n_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed accesses, an SRAM model, a
// cycle-indexed behavioural model of the access timeline, and a write
// scoreboard fed from an expected queue.
module tb_mem_access_ctrl;

  localparam int W  = 2;          // WAIT_CYCLES
  localparam int PH = W + 1;      // cycles per half-phase
  localparam int N  = 2 * PH;     // phase cycles per access

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        MEM_R_en, MEM_W_en;
  logic [31:0] ALU_result, ST_val;
  logic        freeze, ready;
  logic [31:0] Mem_read_value;
  logic [16:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out, SRAM_DQ_in;
  logic        SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N;
  logic [1:0]  dbg_state;

  mem_access_ctrl #(.SRAM_AW(17), .WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst),
    .MEM_R_en(MEM_R_en), .MEM_W_en(MEM_W_en),
    .ALU_result(ALU_result), .ST_val(ST_val),
    .freeze(freeze), .Mem_read_value(Mem_read_value), .ready(ready),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_in(SRAM_DQ_in),
    .SRAM_DQ_oe(SRAM_DQ_oe), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
    .dbg_state_o(dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- SRAM model ----------------
  logic [15:0] sram_mem [0:131071];
  logic [15:0] exp_mem  [0:131071];
  logic [32:0] exp_q[$];
  int          n_reads   = 0;
  int          exp_reads = 0;

  assign SRAM_DQ_in = (!SRAM_OE_N) ? sram_mem[SRAM_ADDR] : 16'h0000;

  // A write lands on the rising edge of the write strobe (ignored under reset).
  always @(posedge SRAM_WE_N) begin
    logic [32:0] e;
    if (rst) begin
      sram_mem[SRAM_ADDR] = SRAM_DQ_out;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sram_write_unexpected actual=0x%0h expected=none", {SRAM_ADDR, SRAM_DQ_out});
      end else begin
        e = exp_q.pop_front();
        check("sram_write", {31'd0, SRAM_ADDR, SRAM_DQ_out}, {31'd0, e});
      end
    end
  end

  always @(negedge SRAM_OE_N) begin
    if (rst) n_reads++;
  end

  // ---------------- behavioural model + compare ----------------
  // m_k is the cycle index within an access: 0 = request cycle,
  // 1..N = half-word phases, N+1 = completion cycle, -1 = idle.
  int          m_k = -1;
  logic        m_store;
  logic [15:0] m_word;
  logic [31:0] m_data;
  logic [31:0] m_rv = 32'd0;

  always @(negedge clk) begin
    logic        e_freeze, e_ready, e_we_n, e_oe_n, e_dq_oe;
    logic [16:0] e_addr;
    logic [15:0] e_dq;
    logic [31:0] off;
    int          ph, pos;
    if (!rst) begin
      m_k  = -1;
      m_rv = 32'd0;
    end else begin
      if (m_k >= 0) m_k++;
      if (m_k > N + 1) m_k = -1;
      if (m_k < 0 && (MEM_R_en || MEM_W_en)) begin
        m_k     = 0;
        m_store = MEM_W_en;
        off     = ALU_result - 32'd1024;
        m_word  = off[17:2];
        m_data  = ST_val;
      end
    end
    e_freeze = rst && (m_k >= 0) && (m_k <= N);
    e_ready  = (m_k == N + 1);
    e_we_n   = 1'b1;
    e_oe_n   = 1'b1;
    e_dq_oe  = 1'b0;
    e_addr   = 17'd0;
    e_dq     = 16'd0;
    if (m_k >= 1 && m_k <= N) begin
      ph     = (m_k - 1) / PH;
      pos    = (m_k - 1) % PH;
      e_addr = {m_word, ph[0]};
      if (m_store) begin
        e_dq_oe = 1'b1;
        e_dq    = (ph == 1) ? m_data[31:16] : m_data[15:0];
        e_we_n  = (pos == W);
        if (pos == W - 1) begin
          exp_q.push_back({e_addr, e_dq});
          exp_mem[e_addr] = e_dq;
        end
      end else begin
        e_oe_n = 1'b0;
        if (m_k == 1) exp_reads++;
      end
    end
    if (m_k == N + 1 && !m_store) m_rv = {exp_mem[{m_word, 1'b1}], exp_mem[{m_word, 1'b0}]};

    check("freeze", {63'd0, freeze}, {63'd0, e_freeze});
    check("ready", {63'd0, ready}, {63'd0, e_ready});
    check("we_n", {63'd0, SRAM_WE_N}, {63'd0, e_we_n});
    check("oe_n", {63'd0, SRAM_OE_N}, {63'd0, e_oe_n});
    check("dq_oe", {63'd0, SRAM_DQ_oe}, {63'd0, e_dq_oe});
    check("mem_read_value", {32'd0, Mem_read_value}, {32'd0, m_rv});
    if (!rst || (m_k >= 1 && m_k <= N)) check("sram_addr", {47'd0, SRAM_ADDR}, {47'd0, e_addr});
    if (!rst || (m_k >= 1 && m_k <= N && m_store)) check("dq_out", {48'd0, SRAM_DQ_out}, {48'd0, e_dq});
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1: drives a request, scrambles the inputs after the
  // request cycle, and returns in the cycle right after ready.
  task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [16:0] exp_a1,
                           input logic [16:0] exp_a4);
    int          fz;
    int          rdy;
    logic [16:0] a1, a4;
    fz  = 0;
    rdy = -1;
    a1  = '0;
    a4  = '0;
    MEM_R_en   = r;
    MEM_W_en   = w;
    ALU_result = a;
    ST_val     = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (freeze) fz++;
      if (i == 1) a1 = SRAM_ADDR;
      if (i == 4) a4 = SRAM_ADDR;
      if (ready && rdy < 0) rdy = i;
      @(posedge clk);
      #1;
      MEM_R_en   = 1'b0;
      MEM_W_en   = 1'b0;
      ALU_result = $urandom_range(32'h0000_FFFF, 32'h0000_0000);
      ST_val     = $urandom;
      if (rdy >= 0) break;
    end
    check("freeze_len", 64'(fz), 64'd7);
    check("ready_cycle", 64'(rdy), 64'd7);
    check("lo_phase_addr", {47'd0, a1}, {47'd0, exp_a1});
    check("hi_phase_addr", {47'd0, a4}, {47'd0, exp_a4});
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 131072; i++) begin
      sram_mem[i] = 16'h0000;
      exp_mem[i]  = 16'h0000;
    end
    sram_mem[0] = 16'h1234; exp_mem[0] = 16'h1234;
    sram_mem[1] = 16'h5678; exp_mem[1] = 16'h5678;

    // Reset held with a pending load: nothing may happen.
    rst        = 1'b0;
    MEM_R_en   = 1'b1;
    MEM_W_en   = 1'b0;
    ALU_result = 32'd1032;
    ST_val     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_freeze", {63'd0, freeze}, 64'd0);
    check("rst_we_n", {63'd0, SRAM_WE_N}, 64'd1);
    check("rst_oe_n", {63'd0, SRAM_OE_N}, 64'd1);
    check("rst_rv", {32'd0, Mem_read_value}, 64'd0);
    MEM_R_en = 1'b0;
    rst      = 1'b1;
    idle_cycles(2);

    // Store aborted by reset during the high phase.
    MEM_W_en   = 1'b1;
    ALU_result = 32'd1040;
    ST_val     = 32'h1111_2222;
    @(posedge clk);
    #1;
    MEM_W_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    check("pre_abort_we_n", {63'd0, SRAM_WE_N}, 64'd0);
    rst = 1'b0;
    #1;
    check("abort_we_n", {63'd0, SRAM_WE_N}, 64'd1);
    check("abort_dq_oe", {63'd0, SRAM_DQ_oe}, 64'd0);
    check("abort_freeze", {63'd0, freeze}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check("abort_state_idle", {62'd0, dbg_state}, 64'd0);
    check("abort_rv", {32'd0, Mem_read_value}, 64'd0);
    idle_cycles(2);

    // Store then load at 1032.
    do_access(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 17'd4, 17'd5);
    check("store_lo_word", {48'd0, sram_mem[4]}, 64'h0000_0000_0000_BEEF);
    check("store_hi_word", {48'd0, sram_mem[5]}, 64'h0000_0000_0000_DEAD);
    idle_cycles(1);
    do_access(1'b1, 1'b0, 32'd1032, 32'd0, 17'd4, 17'd5);
    check("load_value", {32'd0, Mem_read_value}, 64'h0000_0000_DEAD_BEEF);
    idle_cycles(3);
    check("load_value_held", {32'd0, Mem_read_value}, 64'h0000_0000_DEAD_BEEF);

    // Back-to-back load 1024 then store 1028.
    do_access(1'b1, 1'b0, 32'd1024, 32'd0, 17'd0, 17'd1);
    do_access(1'b0, 1'b1, 32'd1028, 32'hCAFE_F00D, 17'd2, 17'd3);
    check("b2b_rv_after_store", {32'd0, Mem_read_value}, 64'h0000_0000_5678_1234);
    check("b2b_store_lo", {48'd0, sram_mem[2]}, 64'h0000_0000_0000_F00D);
    check("b2b_store_hi", {48'd0, sram_mem[3]}, 64'h0000_0000_0000_CAFE);

    // Both enables set, address below the window: wrapped store.
    idle_cycles(1);
    do_access(1'b1, 1'b1, 32'd1020, 32'h0BAD_C0DE, 17'h1FFFE, 17'h1FFFF);
    check("wrap_lo", {48'd0, sram_mem[17'h1FFFE]}, 64'h0000_0000_0000_C0DE);
    check("wrap_hi", {48'd0, sram_mem[17'h1FFFF]}, 64'h0000_0000_0000_0BAD);
    check("both_rv_unchanged", {32'd0, Mem_read_value}, 64'h0000_0000_5678_1234);

    idle_cycles(3);
    check("aborted_lo_written", {48'd0, sram_mem[8]}, 64'h0000_0000_0000_2222);
    check("aborted_hi_not_written", {48'd0, sram_mem[9]}, 64'd0);
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    check("read_count", 64'(n_reads), 64'(exp_reads));
    check("read_count_lit", 64'(n_reads), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
